// File: rtl/fft_pkg.sv
// Shared constants and FSM state type for the FFT butterfly address generator.
package fft_pkg;

   localparam int unsigned MAX_N      = 32;
   localparam int unsigned ADDR_WIDTH = $clog2(MAX_N);
   localparam int unsigned STAGE_W    = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/fft_n_decode.sv
// Maps a requested transform size to log2(N) and flags sizes outside {2, 4, ..., MAX_N}.
module fft_n_decode #(
   parameter int unsigned MAX_N      = fft_pkg::MAX_N,
   parameter int unsigned ADDR_WIDTH = $clog2(MAX_N)
) (
   input  logic [ADDR_WIDTH:0]            n_points,
   output logic [fft_pkg::STAGE_W-1:0]    log2n_c,
   output logic                           valid_c
);

   localparam int unsigned NW = ADDR_WIDTH + 1;
   localparam int unsigned SW = fft_pkg::STAGE_W;

   always_comb begin
      log2n_c = '0;
      valid_c = 1'b0;
      for (int unsigned i = 1; i <= ADDR_WIDTH; i++) begin
         if (n_points == (NW'(1) << i)) begin
            log2n_c = SW'(i);
            valid_c = 1'b1;
         end
      end
      // Non-power-of-two MAX_N overrides still cap the accepted size
      if (n_points > NW'(MAX_N)) begin
         log2n_c = '0;
         valid_c = 1'b0;
      end
   end

endmodule

// File: rtl/fft_addr_gen.sv
// Radix-2 FFT butterfly descriptor generator: walks stages and butterflies, emitting operand
// addresses and twiddle indices. Define FFT_ADDR_GEN_STAGE_GAP_EN for a one-cycle bubble between stages.
module fft_addr_gen #(
   parameter int unsigned MAX_N      = fft_pkg::MAX_N,
   parameter int unsigned ADDR_WIDTH = $clog2(MAX_N)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   n_points,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] addr_a,
   output logic [ADDR_WIDTH-1:0] addr_b,
   output logic [ADDR_WIDTH-1:0] tw_k,
   output logic [ADDR_WIDTH:0]   tw_n,
   output logic [2:0]            stage,
   output logic                  last,
   output logic                  busy,
   output logic                  done,
   output logic                  cfg_err
);

   localparam int unsigned AW = ADDR_WIDTH;
   localparam int unsigned NW = ADDR_WIDTH + 1;
   localparam int unsigned SW = fft_pkg::STAGE_W;

   fft_pkg::state_e state_q, state_d;

   logic [SW-1:0] stg_q, stg_d;
   logic [AW-1:0] b_q, b_d;
   logic [SW-1:0] log2n_q, log2n_d;

   logic          valid_q, valid_d;
   logic [AW-1:0] addr_a_q, addr_a_d;
   logic [AW-1:0] addr_b_q, addr_b_d;
   logic [AW-1:0] tw_k_q, tw_k_d;
   logic [NW-1:0] tw_n_q, tw_n_d;
   logic [SW-1:0] stage_q, stage_d;
   logic          last_q, last_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          cfg_err_q, cfg_err_d;

   logic [SW-1:0] dec_log2n_c;
   logic          dec_valid_c;

   logic [AW-1:0] b_max_c;
   logic [AW-1:0] b_max_d_c;
   logic [AW-1:0] half_c;
   logic [AW-1:0] pos_c;
   logic [AW-1:0] grp_c;
   logic [AW-1:0] a_c;

   fft_n_decode #(
      .MAX_N      (MAX_N),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_n_decode (
      .n_points (n_points),
      .log2n_c  (dec_log2n_c),
      .valid_c  (dec_valid_c)
   );

   // Index of the final butterfly in a stage, for the current and the next transform size
   assign b_max_c   = AW'((NW'(1) << log2n_q) >> 1) - AW'(1);
   assign b_max_d_c = AW'((NW'(1) << log2n_d) >> 1) - AW'(1);

   // Sequencing: state, stage and butterfly counters
   always_comb begin
      state_d   = state_q;
      stg_d     = stg_q;
      b_d       = b_q;
      log2n_d   = log2n_q;
      valid_d   = valid_q;
      cfg_err_d = 1'b0;
      done_d    = 1'b0;

      case (state_q)
         fft_pkg::IDLE: begin
            valid_d = 1'b0;
            if (start) begin
               if (dec_valid_c) begin
                  state_d = fft_pkg::RUN;
                  stg_d   = '0;
                  b_d     = '0;
                  log2n_d = dec_log2n_c;
                  valid_d = 1'b1;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         fft_pkg::RUN: begin
            if (!valid_q) begin
               valid_d = 1'b1;
            end else if (out_ready) begin
               if (b_q == b_max_c) begin
                  b_d = '0;
                  if (stg_q == log2n_q - SW'(1)) begin
                     state_d = fft_pkg::DONE;
                     stg_d   = '0;
                     valid_d = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     stg_d = stg_q + SW'(1);
`ifdef FFT_ADDR_GEN_STAGE_GAP_EN
                     valid_d = 1'b0;
`else
                     valid_d = 1'b1;
`endif
                  end
               end else begin
                  b_d = b_q + AW'(1);
               end
            end
         end
         fft_pkg::DONE: begin
            state_d = fft_pkg::IDLE;
            valid_d = 1'b0;
         end
         default: begin
            state_d = fft_pkg::IDLE;
            valid_d = 1'b0;
         end
      endcase

      busy_d = (state_d != fft_pkg::IDLE);
   end

   // Descriptor for the next (stage, butterfly); zeroed whenever no descriptor is offered
   always_comb begin
      half_c   = AW'(1) << stg_d;
      pos_c    = b_d & (half_c - AW'(1));
      grp_c    = b_d >> stg_d;
      a_c      = ((grp_c << stg_d) << 1) | pos_c;

      addr_a_d = '0;
      addr_b_d = '0;
      tw_k_d   = '0;
      tw_n_d   = '0;
      stage_d  = '0;
      last_d   = 1'b0;
      if (valid_d) begin
         addr_a_d = a_c;
         addr_b_d = a_c + half_c;
         tw_k_d   = pos_c;
         tw_n_d   = NW'(half_c) << 1;
         stage_d  = stg_d;
         last_d   = (b_d == b_max_d_c) && (stg_d == log2n_d - SW'(1));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= fft_pkg::IDLE;
         stg_q     <= '0;
         b_q       <= '0;
         log2n_q   <= '0;
         valid_q   <= 1'b0;
         addr_a_q  <= '0;
         addr_b_q  <= '0;
         tw_k_q    <= '0;
         tw_n_q    <= '0;
         stage_q   <= '0;
         last_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         stg_q     <= stg_d;
         b_q       <= b_d;
         log2n_q   <= log2n_d;
         valid_q   <= valid_d;
         addr_a_q  <= addr_a_d;
         addr_b_q  <= addr_b_d;
         tw_k_q    <= tw_k_d;
         tw_n_q    <= tw_n_d;
         stage_q   <= stage_d;
         last_q    <= last_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign out_valid = valid_q;
   assign addr_a    = addr_a_q;
   assign addr_b    = addr_b_q;
   assign tw_k      = tw_k_q;
   assign tw_n      = tw_n_q;
   assign stage     = stage_q;
   assign last      = last_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_fft_addr_gen.sv
// Scoreboard bench for fft_addr_gen: stimulus pushes expected descriptors, a negedge monitor checks them.
module tb_fft_addr_gen;

   localparam int AW = 5;
   localparam int NW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [NW-1:0] n_points;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] addr_a, addr_b, tw_k;
   logic [NW-1:0] tw_n;
   logic [2:0]    stage;
   logic          last, busy, done, cfg_err;

   typedef struct packed {
      logic [4:0] a;
      logic [4:0] b;
      logic [4:0] k;
      logic [5:0] n;
      logic [2:0] s;
      logic       l;
   } desc_t;

   desc_t exp_q[$];
   desc_t prev_d;
   desc_t mon_e;
   bit    prev_stall = 1'b0;
   bit    rand_ready = 1'b0;
   int    tests = 0;
   int    fails = 0;
   int    xfer_cnt = 0;
   int    bubble_cnt = 0;

`ifdef FFT_ADDR_GEN_STAGE_GAP_EN
   localparam bit GAP = 1'b1;
`else
   localparam bit GAP = 1'b0;
`endif

   always #5 clk = ~clk;

   fft_addr_gen dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .n_points  (n_points),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .addr_a    (addr_a),
      .addr_b    (addr_b),
      .tw_k      (tw_k),
      .tw_n      (tw_n),
      .stage     (stage),
      .last      (last),
      .busy      (busy),
      .done      (done),
      .cfg_err   (cfg_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic desc_t cur_desc();
      desc_t d;
      d.a = addr_a;
      d.b = addr_b;
      d.k = tw_k;
      d.n = tw_n;
      d.s = stage;
      d.l = last;
      return d;
   endfunction

   function automatic logic [31:0] all_outs();
      return 32'({out_valid, addr_a, addr_b, tw_k, tw_n, stage, last, busy, done, cfg_err});
   endfunction

   task automatic push(input int a, input int b, input int k, input int n, input int s, input int l);
      desc_t d;
      d.a = 5'(a);
      d.b = 5'(b);
      d.k = 5'(k);
      d.n = 6'(n);
      d.s = 3'(s);
      d.l = 1'(l);
      exp_q.push_back(d);
   endtask

   // Reference walk: group-major, position-minor within each stage
   task automatic push_model(input int n);
      int lg, half, groups;
      lg = $clog2(n);
      for (int s = 0; s < lg; s++) begin
         half   = 1 << s;
         groups = n / (2 * half);
         for (int g = 0; g < groups; g++)
            for (int p = 0; p < half; p++)
               push(g * 2 * half + p, g * 2 * half + p + half, p, 2 * half, s,
                    int'((s == lg - 1) && (g == groups - 1) && (p == half - 1)));
      end
   endtask

   task automatic do_start(input int n);
      @(posedge clk);
      #1;
      start    = 1'b1;
      n_points = NW'(n);
      @(posedge clk);
      #1;
      start    = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk({name, "_done_seen"}, 32'(seen), 32'd1);
   endtask

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: every transfer pops the scoreboard; stalls must hold; idle outputs must be zero
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_hold", 32'(cur_desc()), 32'(prev_d));
         end
         if (out_valid) begin
            prev_stall = !out_ready;
            prev_d     = cur_desc();
            if (out_ready) begin
               xfer_cnt++;
               chk("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  mon_e = exp_q.pop_front();
                  chk("desc", 32'(cur_desc()), 32'(mon_e));
               end
            end
         end else begin
            prev_stall = 1'b0;
            chk("idle_zero", 32'(cur_desc()), 32'd0);
            if (busy && !done) bubble_cnt++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int bad_n[5];
      bit found;
      bad_n = '{12, 0, 1, 3, 48};
      rst      = 1'b1;
      start    = 1'b0;
      n_points = '0;
      #3;
      chk("reset_outputs", all_outs(), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // N=2: single butterfly, done the following cycle
      xfer_cnt = 0;
      push(0, 1, 0, 2, 0, 1);
      do_start(2);
      chk("n2_valid_latency", 32'(out_valid), 32'd1);
      chk("n2_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      chk("n2_done", 32'(done), 32'd1);
      chk("n2_valid_after", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("n2_done_pulse", 32'(done), 32'd0);
      chk("n2_idle_busy", 32'(busy), 32'd0);
      chk("n2_xfers", 32'(xfer_cnt), 32'd1);

      // N=4: bubble between the stages only with the gap option
      xfer_cnt   = 0;
      bubble_cnt = 0;
      push(0, 1, 0, 2, 0, 0);
      push(2, 3, 0, 2, 0, 0);
      push(0, 2, 0, 4, 1, 0);
      push(1, 3, 1, 4, 1, 1);
      do_start(4);
      wait_done("n4", 50);
      chk("n4_xfers", 32'(xfer_cnt), 32'd4);
      chk("n4_bubbles", 32'(bubble_cnt), GAP ? 32'd1 : 32'd0);
      chk("n4_queue_empty", 32'(exp_q.size()), 32'd0);

      // Illegal sizes: one-cycle cfg_err, nothing starts
      foreach (bad_n[i]) begin
         do_start(bad_n[i]);
         chk("bad_cfg_err", 32'(cfg_err), 32'd1);
         chk("bad_busy", 32'(busy), 32'd0);
         chk("bad_valid", 32'(out_valid), 32'd0);
         @(posedge clk);
         #1;
         chk("bad_cfg_err_pulse", 32'(cfg_err), 32'd0);
      end

      // N=32 with random backpressure and an ignored start mid-run
      xfer_cnt   = 0;
      bubble_cnt = 0;
      rand_ready = 1'b1;
      push_model(32);
      do_start(32);
      repeat (10) @(posedge clk);
      do_start(4);
      chk("busy_start_no_err", 32'(cfg_err), 32'd0);
      chk("busy_start_busy", 32'(busy), 32'd1);
      wait_done("n32", 3000);
      rand_ready = 1'b0;
      chk("n32_xfers", 32'(xfer_cnt), 32'd80);
      chk("n32_bubbles", 32'(bubble_cnt), GAP ? 32'd4 : 32'd0);
      chk("n32_queue_empty", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
      chk("n32_done_pulse", 32'(done), 32'd0);

      // N=16 aborted by reset during stage 2
      xfer_cnt = 0;
      push_model(16);
      do_start(16);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (out_valid && stage == 3'd2) found = 1'b1;
      end
      chk("n16_reached_stage2", 32'(found), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_reset_outputs", all_outs(), 32'd0);
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      #1;
      rst = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done || busy || out_valid) found = 1'b1;
      end
      chk("no_done_after_abort", 32'(found), 32'd0);

      // N=8 after reset, hand-computed table (stage 1, b=3 -> 5,7,1,4)
      xfer_cnt = 0;
      push(0, 1, 0, 2, 0, 0); push(2, 3, 0, 2, 0, 0); push(4, 5, 0, 2, 0, 0); push(6, 7, 0, 2, 0, 0);
      push(0, 2, 0, 4, 1, 0); push(1, 3, 1, 4, 1, 0); push(4, 6, 0, 4, 1, 0); push(5, 7, 1, 4, 1, 0);
      push(0, 4, 0, 8, 2, 0); push(1, 5, 1, 8, 2, 0); push(2, 6, 2, 8, 2, 0); push(3, 7, 3, 8, 2, 1);
      do_start(8);
      chk("n8_restart_valid", 32'(out_valid), 32'd1);
      wait_done("n8", 100);
      chk("n8_xfers", 32'(xfer_cnt), 32'd12);
      chk("n8_queue_empty", 32'(exp_q.size()), 32'd0);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
